// File: rtl/carry_pkg.sv
// Shared opcode constants and carry-chain operand decode for carry_accumulator.
package carry_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_HOLD  = OP_W'(0);
   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_INC   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_DEC   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_CLEAR = OP_W'(6);

   // Which value feeds the B side of the carry chain.
   typedef enum logic [1:0] {
      SEL_B    = 2'd0,
      SEL_NB   = 2'd1,
      SEL_ZERO = 2'd2,
      SEL_ONES = 2'd3
   } opnd_sel_e;

   typedef struct packed {
      opnd_sel_e sel;
      logic      cin;
   } carry_ctrl_t;

   // Map an opcode to operand select and chain carry-in.
   function automatic carry_ctrl_t decode_op(input logic [OP_W-1:0] op, input logic cin);
      carry_ctrl_t c;
      c.sel = SEL_ZERO;
      c.cin = 1'b0;
      case (op)
         OP_ADD: begin c.sel = SEL_B;    c.cin = cin;  end
         OP_SUB: begin c.sel = SEL_NB;   c.cin = cin;  end
         OP_INC: begin c.sel = SEL_ZERO; c.cin = 1'b1; end
         OP_DEC: begin c.sel = SEL_ONES; c.cin = 1'b0; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/carry_slice.sv
// Two-bit propagate/generate ripple-carry slice.
module carry_slice (
   input  logic A0,
   input  logic A1,
   input  logic B0,
   input  logic B1,
   input  logic CIN,
   output logic S0,
   output logic S1,
   output logic COUT0,
   output logic COUT
);

   logic p0;
   logic p1;

   // Per-bit propagate selects between the incoming carry and the generate term.
   always_comb begin
      p0    = A0 ^ B0;
      p1    = A1 ^ B1;
      S0    = p0 ^ CIN;
      COUT0 = p0 ? CIN : (A0 & B0);
      S1    = p1 ^ COUT0;
      COUT  = p1 ? COUT0 : (A1 & B1);
   end

endmodule

// File: rtl/carry_accumulator.sv
// Registered accumulator/counter on a ripple carry chain (ADD/SUB/INC/DEC/LOAD/CLEAR).
// Optional unsigned saturation: define CARRY_ACC_SATURATE_EN.
module carry_accumulator
   import carry_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic [OP_W-1:0]  OP,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic [WIDTH-1:0] ACC,
   output logic             COUT,
   output logic             OVF,
   output logic             ZERO,
   output logic             TC,
   output logic             SAT,
   output logic             DONE
);

   localparam int unsigned NSLICE = WIDTH / 2;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;

   carry_ctrl_t      ctrl;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] sum;
   logic [NSLICE:0]  carry;
   logic             c_msb;
   logic [WIDTH-1:0] acc_res;
   logic             clamp;

   // Operand select for the B side of the chain.
   always_comb begin
      ctrl = decode_op(OP, CIN);
      case (ctrl.sel)
         SEL_B:    opnd = B;
         SEL_NB:   opnd = ~B;
         SEL_ZERO: opnd = '0;
         default:  opnd = '1;
      endcase
   end

   assign carry[0] = ctrl.cin;

   // Ripple chain; the top slice's mid carry is the carry into the MSB.
   for (genvar i = 0; i < NSLICE; i++) begin : g_slice
      if (i == NSLICE - 1) begin : g_top
         carry_slice u_slice (
            .A0   (acc_q[2*i]),
            .A1   (acc_q[2*i+1]),
            .B0   (opnd[2*i]),
            .B1   (opnd[2*i+1]),
            .CIN  (carry[i]),
            .S0   (sum[2*i]),
            .S1   (sum[2*i+1]),
            .COUT0(c_msb),
            .COUT (carry[i+1])
         );
      end else begin : g_mid
         logic c0_unused;
         carry_slice u_slice (
            .A0   (acc_q[2*i]),
            .A1   (acc_q[2*i+1]),
            .B0   (opnd[2*i]),
            .B1   (opnd[2*i+1]),
            .CIN  (carry[i]),
            .S0   (sum[2*i]),
            .S1   (sum[2*i+1]),
            .COUT0(c0_unused),
            .COUT (carry[i+1])
         );
      end
   end

`ifdef CARRY_ACC_SATURATE_EN
   logic sat_q, sat_d;
   logic up;

   // Clamp toward all-ones on an upward carry, toward zero on a borrow.
   always_comb begin
      up      = (OP == OP_ADD) || (OP == OP_INC);
      clamp   = up ? carry[NSLICE] : ~carry[NSLICE];
      acc_res = clamp ? (up ? '1 : '0) : sum;
   end

   assign SAT = sat_q;
`else
   assign clamp   = 1'b0;
   assign acc_res = sum;
   assign SAT     = 1'b0;
`endif

   // Next-state for accumulator and flags; anything not accepted holds.
   always_comb begin
      acc_d  = acc_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      tc_d   = tc_q;
      done_d = 1'b0;
`ifdef CARRY_ACC_SATURATE_EN
      sat_d  = sat_q;
`endif
      if (EN) begin
         case (OP)
            OP_LOAD, OP_CLEAR: begin
               acc_d  = (OP == OP_LOAD) ? B : '0;
               cout_d = 1'b0;
               ovf_d  = 1'b0;
               tc_d   = 1'b0;
               done_d = 1'b1;
`ifdef CARRY_ACC_SATURATE_EN
               sat_d  = 1'b0;
`endif
            end
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
               acc_d  = acc_res;
               cout_d = carry[NSLICE];
               ovf_d  = c_msb ^ carry[NSLICE];
               tc_d   = ((OP == OP_INC) && (&sum)) || ((OP == OP_DEC) && (sum == '0));
               done_d = 1'b1;
`ifdef CARRY_ACC_SATURATE_EN
               sat_d  = sat_q | clamp;
`endif
            end
            default: ;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         tc_q   <= 1'b0;
         done_q <= 1'b0;
`ifdef CARRY_ACC_SATURATE_EN
         sat_q  <= 1'b0;
`endif
      end else begin
         acc_q  <= acc_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         tc_q   <= tc_d;
         done_q <= done_d;
`ifdef CARRY_ACC_SATURATE_EN
         sat_q  <= sat_d;
`endif
      end
   end

   assign ACC  = acc_q;
   assign COUT = cout_q;
   assign OVF  = ovf_q;
   assign TC   = tc_q;
   assign DONE = done_q;
   assign ZERO = (acc_q == '0);

   logic unused_clamp;
   assign unused_clamp = clamp;

endmodule
